// File: rtl/umi_write_pkg.sv
// rtl/umi_write_pkg.sv - UMI write responder opcodes, state encoding and decode helpers
package umi_write_pkg;

    localparam logic [7:0]  UMI_REQ_WRITE  = 8'h03;
    localparam logic [7:0]  UMI_REQ_POSTED = 8'h05;
    localparam logic [7:0]  UMI_RESP_WRITE = 8'h04;
    localparam logic [7:0]  UMI_REQ_INVALID = 8'h00;
    localparam logic [23:0] UMI_ERR_FIELD  = 24'h00_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_write(input logic [7:0] opcode);
        return (opcode == UMI_REQ_WRITE) || (opcode == UMI_REQ_POSTED);
    endfunction

    function automatic logic is_posted(input logic [7:0] opcode);
        return opcode == UMI_REQ_POSTED;
    endfunction

endpackage

// File: rtl/umi_write_resp_fmt.sv
// rtl/umi_write_resp_fmt.sv - combinational write-response formatter (address swap, opcode/error field)
module umi_write_resp_fmt
    import umi_write_pkg::*;
#(
    parameter int CW = 32,
    parameter int AW = 64
) (
    input  logic [CW-1:0] req_cmd,
    input  logic [AW-1:0] req_dstaddr,
    input  logic [AW-1:0] req_srcaddr,
    input  logic          err,
    output logic [CW-1:0] resp_cmd,
    output logic [AW-1:0] resp_dstaddr,
    output logic [AW-1:0] resp_srcaddr
);

    localparam logic [CW-9:0] ERR_HI = (CW-8)'(UMI_ERR_FIELD);

    // Upper command bits pass through untouched unless this is an error response.
    assign resp_cmd     = {(err ? ERR_HI : req_cmd[CW-1:8]), UMI_RESP_WRITE};
    assign resp_dstaddr = req_srcaddr;
    assign resp_srcaddr = req_dstaddr;

endmodule

// File: rtl/umi_write_responder.sv
// rtl/umi_write_responder.sv - UMI device write endpoint; UMI_WRITE_RESP_ERR_EN adds error responses to non-write requests
module umi_write_responder
    import umi_write_pkg::*;
#(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          udev_req_valid,
    input  logic [CW-1:0] udev_req_cmd,
    input  logic [AW-1:0] udev_req_dstaddr,
    input  logic [AW-1:0] udev_req_srcaddr,
    input  logic [DW-1:0] udev_req_data,
    output logic          udev_req_ready,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic          udev_resp_valid,
    output logic [CW-1:0] udev_resp_cmd,
    output logic [AW-1:0] udev_resp_dstaddr,
    output logic [AW-1:0] udev_resp_srcaddr,
    input  logic          udev_resp_ready,
    output logic [15:0]   write_count,
    output logic          drop_pulse
);

    state_t        state_q, state_d;
    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;
    logic          posted_q, posted_d;
    logic          drop_q, drop_d;
    logic [15:0]   write_count_q, write_count_d;
    logic          err_q;
`ifdef UMI_WRITE_RESP_ERR_EN
    logic          err_d;
`else
    assign err_q = 1'b0;
`endif

    logic [CW-1:0] fmt_cmd;
    logic [AW-1:0] fmt_dst, fmt_src;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        dst_d         = dst_q;
        src_d         = src_q;
        data_d        = data_q;
        posted_d      = posted_q;
        drop_d        = 1'b0;
        write_count_d = write_count_q;
`ifdef UMI_WRITE_RESP_ERR_EN
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (udev_req_valid) begin
                    cmd_d  = udev_req_cmd;
                    dst_d  = udev_req_dstaddr;
                    src_d  = udev_req_srcaddr;
                    data_d = udev_req_data;
                    if (is_write(udev_req_cmd[7:0])) begin
                        posted_d = is_posted(udev_req_cmd[7:0]);
                        state_d  = WRITE;
`ifdef UMI_WRITE_RESP_ERR_EN
                        err_d    = 1'b0;
`endif
                    end else begin
                        drop_d = 1'b1;
`ifdef UMI_WRITE_RESP_ERR_EN
                        // Opcode 0 is treated as garbage on the link and never answered.
                        if (udev_req_cmd[7:0] != UMI_REQ_INVALID) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
`endif
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    write_count_d = write_count_q + 16'd1;
                    state_d       = posted_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (udev_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            dst_q         <= '0;
            src_q         <= '0;
            data_q        <= '0;
            posted_q      <= 1'b0;
            drop_q        <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            data_q        <= data_d;
            posted_q      <= posted_d;
            drop_q        <= drop_d;
            write_count_q <= write_count_d;
        end
    end

`ifdef UMI_WRITE_RESP_ERR_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) err_q <= 1'b0;
        else         err_q <= err_d;
    end
`endif

    umi_write_resp_fmt #(.CW(CW), .AW(AW)) u_fmt (
        .req_cmd      (cmd_q),
        .req_dstaddr  (dst_q),
        .req_srcaddr  (src_q),
        .err          (err_q),
        .resp_cmd     (fmt_cmd),
        .resp_dstaddr (fmt_dst),
        .resp_srcaddr (fmt_src)
    );

    // Payload outputs are gated so they read zero whenever their valid is low.
    assign udev_req_ready    = (state_q == IDLE);
    assign mem_valid         = (state_q == WRITE);
    assign mem_addr          = mem_valid ? dst_q  : '0;
    assign mem_wdata         = mem_valid ? data_q : '0;
    assign udev_resp_valid   = (state_q == RESP);
    assign udev_resp_cmd     = udev_resp_valid ? fmt_cmd : '0;
    assign udev_resp_dstaddr = udev_resp_valid ? fmt_dst : '0;
    assign udev_resp_srcaddr = udev_resp_valid ? fmt_src : '0;
    assign write_count       = write_count_q;
    assign drop_pulse        = drop_q;

endmodule

// File: tb/tb_umi_write_responder.sv
// tb/tb_umi_write_responder.sv - directed self-checking bench for umi_write_responder
module tb_umi_write_responder;

    logic        clk = 1'b0;
    logic        nreset;
    logic        udev_req_valid;
    logic [31:0] udev_req_cmd;
    logic [63:0] udev_req_dstaddr;
    logic [63:0] udev_req_srcaddr;
    logic [63:0] udev_req_data;
    logic        udev_req_ready;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic        udev_resp_valid;
    logic [31:0] udev_resp_cmd;
    logic [63:0] udev_resp_dstaddr;
    logic [63:0] udev_resp_srcaddr;
    logic        udev_resp_ready;
    logic [15:0] write_count;
    logic        drop_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    umi_write_responder dut (
        .clk               (clk),
        .nreset            (nreset),
        .udev_req_valid    (udev_req_valid),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_req_ready    (udev_req_ready),
        .mem_valid         (mem_valid),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ready         (mem_ready),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_ready   (udev_resp_ready),
        .write_count       (write_count),
        .drop_pulse        (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] cmd, input logic [63:0] dst,
                           input logic [63:0] src, input logic [63:0] data);
        udev_req_valid   = 1'b1;
        udev_req_cmd     = cmd;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        udev_req_data    = data;
    endtask

    task automatic accept(input logic [31:0] cmd, input logic [63:0] dst,
                          input logic [63:0] src, input logic [63:0] data);
        present(cmd, dst, src, data);
        check("accept_ready", udev_req_ready, 1);
        tick();
        udev_req_valid = 1'b0;
    endtask

    initial begin
        nreset = 1'b0;
        udev_req_valid = 1'b0;
        udev_req_cmd = '0;
        udev_req_dstaddr = '0;
        udev_req_srcaddr = '0;
        udev_req_data = '0;
        mem_ready = 1'b1;
        udev_resp_ready = 1'b1;
        tick();
        tick();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_resp_valid", udev_resp_valid, 0);
        check("rst_resp_cmd", udev_resp_cmd, 0);
        check("rst_count", write_count, 0);
        check("rst_drop", drop_pulse, 0);
        nreset = 1'b1;
        #1;
        check("rst_ready", udev_req_ready, 1);

        // Non-posted write
        accept(32'h0000_0003, 64'h1000, 64'h2000, 64'hDEAD_BEEF);
        check("np_mem_valid", mem_valid, 1);
        check("np_mem_addr", mem_addr, 64'h1000);
        check("np_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        check("np_ready_busy", udev_req_ready, 0);
        check("np_no_resp_yet", udev_resp_valid, 0);
        tick();
        check("np_resp_valid", udev_resp_valid, 1);
        check("np_resp_cmd", udev_resp_cmd, 32'h0000_0004);
        check("np_resp_dst", udev_resp_dstaddr, 64'h2000);
        check("np_resp_src", udev_resp_srcaddr, 64'h1000);
        check("np_count", write_count, 1);
        check("np_mem_done", mem_valid, 0);
        tick();
        check("np_idle_ready", udev_req_ready, 1);
        check("np_resp_done", udev_resp_valid, 0);

        // Posted write
        accept(32'h0000_0005, 64'h40, 64'h77, 64'h55);
        check("p_mem_valid", mem_valid, 1);
        check("p_mem_addr", mem_addr, 64'h40);
        check("p_ready_busy", udev_req_ready, 0);
        tick();
        check("p_ready_back", udev_req_ready, 1);
        check("p_no_resp", udev_resp_valid, 0);
        check("p_count", write_count, 2);

        // Stalls, with upper command bits passed through
        mem_ready = 1'b0;
        udev_resp_ready = 1'b0;
        accept(32'hAB00_0003, 64'h300, 64'h500, 64'h1234);
        for (int i = 0; i < 5; i++) begin
            check("st_mem_valid", mem_valid, 1);
            check("st_mem_addr", mem_addr, 64'h300);
            check("st_mem_wdata", mem_wdata, 64'h1234);
            check("st_ready_low", udev_req_ready, 0);
            check("st_count_hold", write_count, 2);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("st_resp_valid", udev_resp_valid, 1);
            check("st_resp_cmd", udev_resp_cmd, 32'hAB00_0004);
            check("st_resp_dst", udev_resp_dstaddr, 64'h500);
            check("st_resp_src", udev_resp_srcaddr, 64'h300);
            check("st_ready_low2", udev_req_ready, 0);
            check("st_mem_idle", mem_valid, 0);
            tick();
        end
        check("st_count", write_count, 3);
        udev_resp_ready = 1'b1;
        tick();
        check("st_resp_done", udev_resp_valid, 0);
        check("st_ready_back", udev_req_ready, 1);

        // Non-write request
        accept(32'h0000_0002, 64'h700, 64'h800, 64'h0);
        check("dr_pulse", drop_pulse, 1);
        check("dr_no_mem", mem_valid, 0);
`ifdef UMI_WRITE_RESP_ERR_EN
        check("dr_err_valid", udev_resp_valid, 1);
        check("dr_err_cmd", udev_resp_cmd, 32'h0000_0104);
        check("dr_err_dst", udev_resp_dstaddr, 64'h800);
        check("dr_err_src", udev_resp_srcaddr, 64'h700);
`else
        check("dr_no_resp", udev_resp_valid, 0);
        check("dr_ready", udev_req_ready, 1);
`endif
        tick();
        check("dr_pulse_end", drop_pulse, 0);
        check("dr_idle", udev_req_ready, 1);
        check("dr_count", write_count, 3);

        // Opcode 0 is dropped without a response in either build
        accept(32'h0000_0000, 64'h11, 64'h22, 64'h0);
        check("inv_pulse", drop_pulse, 1);
        check("inv_no_resp", udev_resp_valid, 0);
        check("inv_ready", udev_req_ready, 1);
        tick();

        // Counter wrap: preload close to the top instead of 65535 real writes
        force dut.write_count_q = 16'hFFFE;
        tick();
        release dut.write_count_q;
        tick();
        check("wr_preload", write_count, 16'hFFFE);
        accept(32'h0000_0005, 64'h80, 64'h0, 64'h1);
        tick();
        check("wr_ffff", write_count, 16'hFFFF);
        accept(32'h0000_0005, 64'h88, 64'h0, 64'h2);
        tick();
        check("wr_wrap", write_count, 16'h0000);

        // Reset while stalled in RESP
        udev_resp_ready = 1'b0;
        accept(32'h0000_0003, 64'hA0, 64'hB0, 64'hC0);
        tick();
        check("rs_in_resp", udev_resp_valid, 1);
        check("rs_count_pre", write_count, 1);
        #2;
        nreset = 1'b0;
        #1;
        check("rs_resp_async", udev_resp_valid, 0);
        check("rs_count_clr", write_count, 0);
        check("rs_mem_clr", mem_valid, 0);
        tick();
        nreset = 1'b1;
        udev_resp_ready = 1'b1;
        #1;
        check("rs_ready", udev_req_ready, 1);
        check("rs_no_resp", udev_resp_valid, 0);
        accept(32'h0000_0003, 64'h900, 64'h901, 64'hFACE);
        check("rs_mem_addr", mem_addr, 64'h900);
        check("rs_mem_wdata", mem_wdata, 64'hFACE);
        tick();
        check("rs_resp_cmd", udev_resp_cmd, 32'h0000_0004);
        check("rs_resp_dst", udev_resp_dstaddr, 64'h901);
        check("rs_count", write_count, 1);
        tick();
        check("rs_idle", udev_req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/umi_write_responder.md
Name: umi_write_responder

Overview:
Device-side endpoint for UMI write requests.
- Accepts request packets.
- Performs one single-beat write to a local memory-style port.
- Returns a write-response packet for non-posted writes only.
- Posted writes complete silently.
- Sits between the UMI device request/response channels and a local register file or SRAM controller.

Parameters:
CW, 32, command width
AW, 64, address width
DW, 64, data width (one beat per request)

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
udev_req_valid  input  1  request valid
udev_req_cmd  input  CW  request command; opcode in [7:0]
udev_req_dstaddr  input  AW  write target address
udev_req_srcaddr  input  AW  requester return address
udev_req_data  input  DW  write data
udev_req_ready  output  1  request accept
mem_valid  output  1  memory write strobe
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory data
mem_ready  input  1  memory accepts write
udev_resp_valid  output  1  response valid
udev_resp_cmd  output  CW  response command
udev_resp_dstaddr  output  AW  response destination (= request srcaddr)
udev_resp_srcaddr  output  AW  response source (= request dstaddr)
udev_resp_ready  input  1  response accept
write_count  output  16  completed memory writes
drop_pulse  output  1  one-cycle pulse per dropped non-write request

Behaviour:
- One clock domain. Reset is asynchronous and active-low on nreset.
- Reset values:
  - State is IDLE.
  - udev_req_ready=1 as soon as reset deasserts.
  - All other outputs are 0, including write_count.
- A handshake fires when valid&&ready at a clk rise.
- Opcodes (package constants):
  - UMI_REQ_WRITE=8'h03
  - UMI_REQ_POSTED=8'h05
  - UMI_RESP_WRITE=8'h04
- Decode uses cmd[7:0] only.
- FSM states: IDLE, WRITE, RESP.
- IDLE:
  - udev_req_ready=1.
  - On a write or posted handshake: latch cmd, dstaddr, srcaddr and data, plus a posted flag. Next state WRITE.
  - On a handshake with any other opcode: the request is consumed and dropped. drop_pulse=1 next cycle. Stay in IDLE.
- WRITE:
  - udev_req_ready=0.
  - mem_valid=1, with mem_addr and mem_wdata held from the latch.
  - On mem_ready:
    - write_count increments, wrapping 16'hFFFF to 0.
    - Next state is IDLE if posted, otherwise RESP.
  - mem_valid stays asserted until mem_ready; there is no timeout.
- RESP:
  - udev_resp_valid=1.
  - udev_resp_cmd = {latched cmd[CW-1:8], UMI_RESP_WRITE}.
  - Addresses are swapped as listed under Ports.
  - All response fields are stable until udev_resp_ready. Then next state is IDLE.
- Latency, assuming mem_ready and resp_ready are held high:
  - Posted: request accept to mem_valid is 1 cycle; the next accept is 2 cycles later.
  - Non-posted: resp_valid is asserted 2 cycles after accept; the next accept is 3 cycles later.
- No request is accepted outside IDLE; there is no overlap.
- Back-pressure: mem_ready or udev_resp_ready held low stalls indefinitely. Every output stays stable while stalled.
- Reset mid-operation: the in-flight transaction is discarded. No response is emitted. write_count is cleared.
- cmd[CW-1:8] is ignored for decode and only passed through.

Optional Feature:
UMI_WRITE_RESP_ERR_EN
- Defined:
  - A dropped non-write request is still consumed and still pulses drop_pulse.
  - The block then enters RESP and returns UMI_RESP_WRITE with cmd[CW-1:8] replaced by the package constant UMI_ERR_FIELD (24'h00_0001), with addresses swapped.
  - Exception: a request with opcode 8'h00 (invalid) never gets a response.
- Undefined: non-write requests are silently dropped as described in Behaviour.

Decomposition:
- Package umi_write_pkg holds:
  - the opcode constants
  - UMI_ERR_FIELD
  - the state enum {IDLE, WRITE, RESP}
  - decode functions is_write(opcode) and is_posted(opcode)
- One natural sub-module, umi_write_resp_fmt. It is combinational and builds resp_cmd, resp_dstaddr and resp_srcaddr from the latched fields and the error flag.

Test Plan:
- Non-posted write: cmd=32'h0000_0003, dst=64'h1000, src=64'h2000, data=64'hDEAD_BEEF; mem_ready=1, resp_ready=1.
  -> mem_valid with addr 0x1000 and data DEADBEEF.
  -> Then resp_valid with cmd 32'h0000_0004, dst 0x2000, src 0x1000.
  -> write_count=1.
- Posted write: cmd=8'h05, dst=0x40.
  -> mem write to 0x40; resp_valid never asserts.
  -> udev_req_ready returns high 2 cycles after accept.
- Stalls: mem_ready=0 for 5 cycles, then resp_ready=0 for 4 cycles.
  -> mem_* and resp_* hold stable throughout; udev_req_ready=0 throughout.
  -> Exactly one memory write and one response.
- Non-write request: cmd=8'h02.
  -> drop_pulse one cycle; no mem_valid.
  -> With UMI_WRITE_RESP_ERR_EN: response cmd 32'h0000_0104.
- Counter wrap: preload by issuing 65535 posted writes, then issue one more.
  -> write_count wraps to 0.
- Reset: assert nreset low while in RESP with resp_ready=0.
  -> udev_resp_valid=0 immediately (asynchronously); write_count=0.
  -> After release, udev_req_ready=1 and the next write works normally.
